// File: rtl/pipe_ctrl_pkg.sv
// Shared types and opcode constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_FILL     = 2'd0,
      ST_RUN      = 2'd1,
      ST_MEM_WAIT = 2'd2
   } ctrl_state_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;

endpackage

// File: rtl/load_use_detect.sv
// Flags a decode-stage instruction that reads the register a load in EX is about to write.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [31:0] id_instr,
   input  logic        ex_mem_read,
   input  logic [4:0]  ex_rt,
   output logic        load_use
);

   logic [5:0] opcode;
   logic [4:0] rs;
   logic [4:0] rt;
   logic       uses_rt;
   logic       unused_instr_bits;

   assign opcode = id_instr[31:26];
   assign rs     = id_instr[25:21];
   assign rt     = id_instr[20:16];
   // Immediate/rd/funct fields never name a source register.
   assign unused_instr_bits = ^id_instr[15:0];

   assign uses_rt  = (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
   assign load_use = ex_mem_read && (ex_rt != 5'd0) &&
                     ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Pipeline sequencing controller: post-reset fill, load-use stall, branch squash,
// memory freeze with watchdog, and saturating stall/flush counters.
module hazard_ctrl_unit
   import pipe_ctrl_pkg::*;
#(
   parameter int RESET_FILL = 3,
   parameter int WD_LIMIT   = 255,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      id_instr,
   input  logic             ex_mem_read,
   input  logic [4:0]       ex_rt,
   input  logic             mem_branch_taken,
   input  logic             mem_busy,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic             idex_bubble,
   output logic             exmem_flush,
   output logic             pipe_hold,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             wd_err
);

   localparam int FILL_W = $clog2(RESET_FILL + 1);
   localparam int WD_W   = $clog2(WD_LIMIT + 1);

   ctrl_state_e      state_q, state_d;
   logic [FILL_W-1:0] fill_cnt_q, fill_cnt_d;
   logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
   logic              br_pend_q, br_pend_d;
   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic              wd_err_q, wd_err_d;
   logic              load_use;
   logic              branch;
   logic              do_flush;

   load_use_detect u_lu (
      .id_instr    (id_instr),
      .ex_mem_read (ex_mem_read),
      .ex_rt       (ex_rt),
      .load_use    (load_use)
   );

   always_comb begin
      state_d     = state_q;
      fill_cnt_d  = fill_cnt_q;
      wd_cnt_d    = wd_cnt_q;
      br_pend_d   = br_pend_q;
      wd_err_d    = wd_err_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      ifid_flush  = 1'b0;
      idex_bubble = 1'b0;
      exmem_flush = 1'b0;
      pipe_hold   = 1'b0;
      branch      = 1'b0;
      do_flush    = 1'b0;

      case (state_q)
         ST_FILL: begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
            fill_cnt_d  = fill_cnt_q + 1'b1;
            if (fill_cnt_q == FILL_W'(RESET_FILL - 1)) state_d = ST_RUN;
         end
         ST_RUN, ST_MEM_WAIT: begin
            if (mem_busy) begin
               pipe_hold = 1'b1;
               state_d   = ST_MEM_WAIT;
               if (state_q == ST_RUN) begin
                  wd_cnt_d  = WD_W'(1);
                  br_pend_d = mem_branch_taken;
               end else begin
                  if (wd_cnt_q != WD_W'(WD_LIMIT)) wd_cnt_d = wd_cnt_q + 1'b1;
                  if (mem_branch_taken) br_pend_d = 1'b1;
               end
               if (wd_cnt_d == WD_W'(WD_LIMIT)) wd_err_d = 1'b1;
            end else begin
               // br_pend_q is only ever set while frozen, so in RUN this is just the live branch.
               branch = mem_branch_taken | br_pend_q;
               if (branch) begin
                  pc_write    = 1'b1;
                  ifid_flush  = 1'b1;
                  idex_bubble = 1'b1;
                  exmem_flush = 1'b1;
                  do_flush    = 1'b1;
               end else if (load_use) begin
                  idex_bubble = 1'b1;
               end else begin
                  pc_write   = 1'b1;
                  ifid_write = 1'b1;
               end
               br_pend_d = 1'b0;
               wd_cnt_d  = '0;
               state_d   = ST_RUN;
            end
            if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
            if (do_flush && (flush_cnt_q != '1))  flush_cnt_d = flush_cnt_q + 1'b1;
         end
         default: state_d = ST_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         fill_cnt_q  <= '0;
         wd_cnt_q    <= '0;
         br_pend_q   <= 1'b0;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
         wd_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         fill_cnt_q  <= fill_cnt_d;
         wd_cnt_q    <= wd_cnt_d;
         br_pend_q   <= br_pend_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
         wd_err_q    <= wd_err_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;
   assign wd_err    = wd_err_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit: directed scenarios then random traffic,
// all compared cycle by cycle against a behavioural model of the sequencing rules.
module tb_hazard_ctrl_unit;

   localparam int RESET_FILL = 3;
   localparam int WD_LIMIT   = 5;
   localparam int CNT_W      = 3;
   localparam int CMAX       = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic [31:0]      id_instr = '0;
   logic             ex_mem_read = 1'b0;
   logic [4:0]       ex_rt = '0;
   logic             mem_branch_taken = 1'b0;
   logic             mem_busy = 1'b0;
   logic             pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic             wd_err;

   hazard_ctrl_unit #(
      .RESET_FILL (RESET_FILL),
      .WD_LIMIT   (WD_LIMIT),
      .CNT_W      (CNT_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_instr         (id_instr),
      .ex_mem_read      (ex_mem_read),
      .ex_rt            (ex_rt),
      .mem_branch_taken (mem_branch_taken),
      .mem_busy         (mem_busy),
      .pc_write         (pc_write),
      .ifid_write       (ifid_write),
      .ifid_flush       (ifid_flush),
      .idex_bubble      (idex_bubble),
      .exmem_flush      (exmem_flush),
      .pipe_hold        (pipe_hold),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt),
      .wd_err           (wd_err)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Model: cycles since reset, length of current busy run, branch seen during it.
   int m_age, m_streak, m_stall, m_flush;
   bit m_br, m_wderr;

   localparam logic [31:0] ADD_9_8_10 = {6'h00, 5'd8, 5'd10, 5'd9, 5'd0, 6'h20};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic bit ref_load_use(input logic [31:0] ins, input bit mr, input logic [4:0] rt);
      logic [5:0] op;
      bit uses;
      op   = ins[31:26];
      uses = (op == 6'h00) || (op == 6'h2B) || (op == 6'h04);
      return mr && (rt != 5'd0) && ((rt == ins[25:21]) || (uses && (rt == ins[20:16])));
   endfunction

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      m_age = 0; m_streak = 0; m_stall = 0; m_flush = 0; m_br = 0; m_wderr = 0;
      #2;
      chk("rst_ctl", {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold},
          6'b001110);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_flush", flush_cnt, 0);
      chk("rst_wd", wd_err, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic step(input bit busy, input bit bt, input bit mr, input logic [4:0] rt,
                       input logic [31:0] ins);
      bit fill, br, lu;
      logic [5:0] e;
      mem_busy = busy; mem_branch_taken = bt; ex_mem_read = mr; ex_rt = rt; id_instr = ins;
      @(negedge clk);
      fill = (m_age < RESET_FILL);
      br   = 0;
      lu   = ref_load_use(ins, mr, rt);
      // e = {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold}
      if (fill)                 e = 6'b001110;
      else if (busy)            e = 6'b000001;
      else begin
         br = bt | m_br;
         if (br)                e = 6'b101110;
         else if (lu)           e = 6'b000100;
         else                   e = 6'b110000;
      end
      chk("ctl", {pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, pipe_hold}, e);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("flush_cnt", flush_cnt, m_flush);
      chk("wd_err", wd_err, m_wderr);
      if (!fill) begin
         if (busy) begin
            m_streak++;
            m_br = m_br | bt;
            if (m_streak >= WD_LIMIT) m_wderr = 1;
         end else begin
            m_streak = 0;
            m_br     = 0;
            if (br) m_flush = sat_inc(m_flush);
         end
         if (!e[5]) m_stall = sat_inc(m_stall);
      end
      if (m_age < 1000) m_age++;
      @(posedge clk); #1;
   endtask

   logic [5:0] ops [5] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08};

   initial begin
      int busy_left;
      logic [31:0] ins;
      #1;
      // Reset fill: three bubble cycles, then normal fetch.
      do_reset();
      repeat (RESET_FILL) step(0, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);
      chk("fill_stall", stall_cnt, 0);

      // Load-use against ADD $9,$8,$10, then the same with $zero as load target.
      step(0, 0, 1, 5'd8, ADD_9_8_10);
      step(0, 0, 0, 5'd0, ADD_9_8_10);
      chk("lu_stall", stall_cnt, 1);
      step(0, 0, 1, 5'd0, ADD_9_8_10);
      chk("lu_zero", stall_cnt, 1);

      // Branch and load-use together: branch wins, no stall.
      step(0, 1, 1, 5'd8, ADD_9_8_10);
      chk("br_lu_flush", flush_cnt, 1);
      chk("br_lu_stall", stall_cnt, 1);

      // Four-cycle freeze with a branch pulse in cycle 2; flush on release.
      do_reset();
      repeat (RESET_FILL) step(0, 0, 0, 0, 32'h0);
      step(1, 0, 0, 0, 32'h0);
      step(1, 1, 0, 0, 32'h0);
      step(1, 0, 0, 0, 32'h0);
      step(1, 0, 0, 0, 32'h0);
      step(0, 0, 0, 0, 32'h0);
      chk("frz_stall", stall_cnt, 4);
      chk("frz_flush", flush_cnt, 1);

      // Watchdog: busy for 10 cycles trips after the 5th and stays set.
      repeat (4) step(1, 0, 0, 0, 32'h0);
      chk("wd_before", wd_err, 0);
      step(1, 0, 0, 0, 32'h0);
      chk("wd_after", wd_err, 1);
      repeat (5) step(1, 0, 0, 0, 32'h0);
      repeat (2) step(0, 0, 0, 0, 32'h0);
      chk("wd_sticky", wd_err, 1);
      do_reset();

      // Saturation of the stall counter.
      repeat (RESET_FILL) step(0, 0, 0, 0, 32'h0);
      repeat (CMAX + 2) begin
         step(0, 0, 1, 5'd8, ADD_9_8_10);
         step(0, 0, 0, 5'd0, 32'h0);
      end
      chk("stall_sat", stall_cnt, CMAX);

      // Random traffic with occasional asynchronous resets.
      busy_left = 0;
      for (int i = 0; i < 2500; i++) begin
         if ($urandom_range(0, 149) == 0) do_reset();
         if (busy_left == 0 && $urandom_range(0, 6) == 0) busy_left = $urandom_range(1, 8);
         ins = {ops[$urandom_range(0, 4)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                16'($urandom)};
         step(busy_left > 0, $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
              5'($urandom_range(0, 3)), ins);
         if (busy_left > 0) busy_left--;
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
